// File: rtl/rand_pos_gen.sv
// Random screen-position generator: reduces two decorrelated LFSR samples
// modulo X_RANGE / Y_RANGE by repeated subtraction and presents them as (x, y).
module rand_pos_gen #(
    parameter int X_RANGE = 160,
    parameter int Y_RANGE = 120,
    parameter int GAP     = 13
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [12:0] rnd,
    input  logic        req,
    output logic        busy,
    output logic        valid,
    output logic [7:0]  x,
    output logic [6:0]  y
);

    localparam int          CW     = $clog2(GAP + 2);
    localparam logic [12:0] X_LIM  = 13'(X_RANGE);
    localparam logic [12:0] Y_LIM  = 13'(Y_RANGE);
    localparam logic [CW-1:0] GAP_LD = CW'(GAP);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REDUCE_X = 3'd1,
        WAIT     = 3'd2,
        REDUCE_Y = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [12:0]   acc, acc_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    x_n;
    logic [6:0]    y_n;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            x     <= '0;
            y     <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            x     <= x_n;
            y     <= y_n;
        end
    end

    // NOTE: every output of this block is given a hold value first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        x_n     = x;
        y_n     = y;
        case (state)
            IDLE: begin
                if (req) begin
                    acc_n   = rnd;
                    state_n = REDUCE_X;
                end
            end
            REDUCE_X: begin
                if (acc >= X_LIM) begin
                    acc_n = acc - X_LIM;
                end else begin
                    x_n     = acc[7:0];
                    cnt_n   = GAP_LD;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                // Lets the upstream LFSR fully refresh before the y sample.
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    acc_n   = rnd;
                    state_n = REDUCE_Y;
                end
            end
            REDUCE_Y: begin
                if (acc >= Y_LIM) begin
                    acc_n = acc - Y_LIM;
                end else begin
                    y_n     = acc[6:0];
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy  = (state != IDLE);
    assign valid = (state == DONE);

endmodule

// File: tb/tb_rand_pos_gen.sv
// Self-checking bench for rand_pos_gen: directed vector table, hand-written
// corner sequences and randomised requests against a modulo/latency model.
module tb_rand_pos_gen;

    localparam int XR = 160;
    localparam int YR = 120;
    localparam int G  = 13;

    logic        clock;
    logic        reset;
    logic [12:0] rnd;
    logic        req;
    logic        busy, valid;
    logic [7:0]  x;
    logic [6:0]  y;

    logic [12:0] rnd2;
    logic        req2;
    logic        busy2, valid2;
    logic [7:0]  x2;
    logic [6:0]  y2;

    int tests  = 0;
    int failed = 0;

    rand_pos_gen #(.X_RANGE(XR), .Y_RANGE(YR), .GAP(G)) dut (
        .clock(clock), .reset(reset), .rnd(rnd), .req(req),
        .busy(busy), .valid(valid), .x(x), .y(y)
    );

    // Degenerate ranges with no decorrelation gap.
    rand_pos_gen #(.X_RANGE(1), .Y_RANGE(1), .GAP(0)) dut2 (
        .clock(clock), .reset(reset), .rnd(rnd2), .req(req2),
        .busy(busy2), .valid(valid2), .x(x2), .y(y2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int rx;
        int ry;
        int ex;
        int ey;
        int elat;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One request from IDLE. rnd is rx on the accept edge and ry on the edge
    // at which the model says the gap expires; elsewhere it is rx/ry or noise.
    task automatic do_req(input int rx, input int ry, input bit noisy,
                          output int ox, output int oy, output int lat,
                          output int x_early, output int busy_cnt,
                          output int idle_after);
        int qx, qy, jy, ln;
        qx = rx / XR;
        qy = ry / YR;
        jy = qx + G + 2;
        ln = jy + qy + 1;
        ox = -1; oy = -1; lat = -1; x_early = -1; busy_cnt = 0;
        req = 1'b1;
        rnd = 13'(rx);
        step();
        if (busy) busy_cnt++;
        for (int j = 1; j <= ln + 20; j++) begin
            req = noisy ? 1'($urandom) : 1'b0;
            if (j == jy)      rnd = 13'(ry);
            else if (noisy)   rnd = 13'($urandom);
            else              rnd = (j < jy) ? 13'(rx) : 13'(ry);
            step();
            if (j == qx + 1) x_early = int'(x);
            if (busy) busy_cnt++;
            if (valid) begin
                lat = j;
                ox  = int'(x);
                oy  = int'(y);
                break;
            end
        end
        req = 1'b0;
        step();
        idle_after = (!busy && !valid) ? 1 : 0;
    endtask

    initial begin
        vec_t vecs[6];
        int ox, oy, lat, xe, bc, ia;
        int viol;
        int pulses[4];
        int np, prev_v, dbl;

        vecs[0] = '{rx: 500,  ry: 500,  ex: 20,  ey: 20, elat: 23};
        vecs[1] = '{rx: 0,    ry: 8191, ex: 0,   ey: 31, elat: 84};
        vecs[2] = '{rx: 159,  ry: 159,  ex: 159, ey: 39, elat: 17};
        vecs[3] = '{rx: 160,  ry: 120,  ex: 0,   ey: 0,  elat: 18};
        vecs[4] = '{rx: 8191, ry: 0,    ex: 31,  ey: 0,  elat: 67};
        vecs[5] = '{rx: 1,    ry: 1,    ex: 1,   ey: 1,  elat: 16};

        reset = 1'b1; req = 1'b0; rnd = '0; req2 = 1'b0; rnd2 = '0;
        step(); step();
        check("rst_busy",  int'(busy),  0);
        check("rst_valid", int'(valid), 0);
        check("rst_xy",    int'(x) + int'(y), 0);
        reset = 1'b0;

        // Idle with req low: nothing moves.
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            rnd = 13'($urandom);
            step();
            if (busy || valid || x != 0 || y != 0) viol++;
        end
        check("idle_quiet", viol, 0);

        foreach (vecs[i]) begin
            do_req(vecs[i].rx, vecs[i].ry, 1'b0, ox, oy, lat, xe, bc, ia);
            check($sformatf("vec%0d_x", i),       ox,  vecs[i].ex);
            check($sformatf("vec%0d_y", i),       oy,  vecs[i].ey);
            check($sformatf("vec%0d_lat", i),     lat, vecs[i].elat);
            check($sformatf("vec%0d_x_early", i), xe,  vecs[i].ex);
            check($sformatf("vec%0d_busy", i),    bc,  vecs[i].elat + 1);
            check($sformatf("vec%0d_idle", i),    ia,  1);
        end

        // req held high with rnd=159: accepts every 19 cycles.
        req = 1'b1; rnd = 13'd159;
        np = 0; prev_v = 0; dbl = 0; viol = 0;
        for (int e = 1; e <= 80; e++) begin
            step();
            if (valid) begin
                if (np < 4) pulses[np] = e;
                np++;
                if (x != 8'd159 || y != 7'd39) viol++;
            end
            if (valid && prev_v) dbl++;
            prev_v = int'(valid);
        end
        req = 1'b0;
        check("stream_count", np, 4);
        check("stream_first", pulses[0], 18);
        for (int k = 1; k < 4; k++)
            check($sformatf("stream_gap%0d", k), pulses[k] - pulses[k-1], 19);
        check("stream_double", dbl, 0);
        check("stream_xy", viol, 0);
        viol = 1;
        for (int e = 0; e < 40; e++) begin
            step();
            if (!busy) begin
                viol = 0;
                break;
            end
        end
        check("stream_drain", viol, 0);

        // Reset in the 5th WAIT cycle aborts the request.
        req = 1'b1; rnd = 13'd500;
        step();
        req = 1'b0;
        for (int e = 1; e <= 8; e++) step();
        check("abort_pre_x", int'(x), 20);
        check("abort_pre_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        check("abort_busy",  int'(busy),  0);
        check("abort_valid", int'(valid), 0);
        check("abort_x",     int'(x),     0);
        step(); step();
        reset = 1'b0;
        viol = 0;
        for (int e = 0; e < 30; e++) begin
            step();
            if (valid || busy) viol++;
        end
        check("abort_no_valid", viol, 0);
        do_req(500, 500, 1'b0, ox, oy, lat, xe, bc, ia);
        check("abort_next_x",   ox,  20);
        check("abort_next_y",   oy,  20);
        check("abort_next_lat", lat, 23);

        // X_RANGE = Y_RANGE = 1, GAP = 0: latency (37+1)+(0+1)+(37+1).
        req2 = 1'b1; rnd2 = 13'd37;
        step();
        req2 = 1'b0;
        lat = -1;
        for (int j = 1; j <= 200; j++) begin
            step();
            if (valid2) begin
                lat = j;
                ox  = int'(x2);
                oy  = int'(y2);
                break;
            end
        end
        check("deg_lat", lat, 77);
        check("deg_x", ox, 0);
        check("deg_y", oy, 0);
        step();
        check("deg_idle", int'(busy2), 0);

        // Randomised requests against the modulo/latency model.
        for (int i = 0; i < 1000; i++) begin
            int rx, ry, elat;
            rx = (i % 2 == 1) ? int'($urandom_range(0, 8191)) : int'($urandom_range(0, 1023));
            ry = (i % 3 == 0) ? int'($urandom_range(0, 8191)) : int'($urandom_range(0, 1023));
            elat = (rx / XR + 1) + (G + 1) + (ry / YR + 1);
            do_req(rx, ry, 1'b1, ox, oy, lat, xe, bc, ia);
            check("rand_x",       ox,  rx % XR);
            check("rand_y",       oy,  ry % YR);
            check("rand_lat",     lat, elat);
            check("rand_x_early", xe,  rx % XR);
            check("rand_range",   (ox >= 0 && ox < XR && oy >= 0 && oy < YR) ? 1 : 0, 1);
            check("rand_idle",    ia,  1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/rand_pos_gen.md
RAND_POS_GEN -- requirements
Module: rand_pos_gen

Interface
REQ-001 Parameter X_RANGE, default 160: x coordinate range; x SHALL lie in 0..X_RANGE-1; legal values 1..256.
REQ-002 Parameter Y_RANGE, default 120: y coordinate range; y SHALL lie in 0..Y_RANGE-1; legal values 1..128.
REQ-003 Parameter GAP, default 13: decorrelation wait, in cycles, between the x sample and the y sample (one full LFSR refresh).
REQ-004 clock  input  1: rising-edge clock for all state.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 rnd  input  13: free-running pseudo-random value from the upstream LFSR; may change every cycle.
REQ-007 req  input  1: request a new position; sampled only in IDLE.
REQ-008 busy  output  1: high in every state except IDLE.
REQ-009 valid  output  1: one-cycle pulse; new x/y are present.
REQ-010 x  output  8: x coordinate, held until overwritten.
REQ-011 y  output  7: y coordinate, held until overwritten.

Function
REQ-012 The FSM SHALL have the states IDLE, REDUCE_X, WAIT, REDUCE_Y and DONE; any unused encoding SHALL return to IDLE.
REQ-013 IDLE with req=1 at an edge: the 13-bit accumulator acc SHALL load rnd and the state SHALL go to REDUCE_X.
REQ-014 IDLE with req=0: the state, acc, x and y SHALL be unchanged.
REQ-015 REDUCE_X, per edge: if acc >= X_RANGE, then acc <= acc - X_RANGE; else x <= acc[7:0], gap counter <= GAP, and the state goes to WAIT.
REQ-016 WAIT, per edge: if counter != 0, the counter SHALL decrement; if counter == 0, acc <= rnd and the state goes to REDUCE_Y.
REQ-017 REDUCE_Y, per edge: if acc >= Y_RANGE, then acc <= acc - Y_RANGE; else y <= acc[6:0] and the state goes to DONE.
REQ-018 DONE SHALL assert valid=1 for exactly that cycle and go to IDLE on the next edge unconditionally.
REQ-019 Latency: the edges from the req-accept edge to entry into DONE SHALL number (qx+1)+(GAP+1)+(qy+1).
  - qx = floor(rnd_x / X_RANGE), qy = floor(rnd_y / Y_RANGE).
  - rnd_x and rnd_y are the rnd values captured per REQ-013 and REQ-016.
REQ-020 The result SHALL equal rnd_x mod X_RANGE and rnd_y mod Y_RANGE exactly; comparison and subtraction are unsigned at 13 bits.
REQ-021 req while busy=1 SHALL be ignored, with no queuing.
REQ-022 req=1 during DONE SHALL NOT be accepted; acceptance occurs in IDLE, at the earliest the following cycle.
REQ-023 A back-to-back request SHALL restart at REQ-013; x and y SHALL keep their old values until overwritten per REQ-015/017.
REQ-024 x SHALL update at the end of REDUCE_X and y at the end of REDUCE_Y, so x changes before valid.
REQ-025 Consumers SHALL read x and y only on valid=1 or while busy=0.
REQ-026 rnd = 0 SHALL be handled normally: 0 is a legal result, even though the LFSR never produces it.
REQ-027 GAP = 0 SHALL give a single WAIT cycle.
REQ-028 X_RANGE = 1 or Y_RANGE = 1 SHALL yield 0 after up to 8192 reduction cycles, with no timeout.

Reset
REQ-029 Asserting reset SHALL set the state to IDLE immediately and clear busy, valid, x, y, acc and the gap counter to 0.
REQ-030 Reset mid-operation SHALL abort the request with no valid pulse; the first accept after release follows REQ-013.

Verification
REQ-031 Reset, then req held low for 20 cycles -> busy=0, valid=0, x=0, y=0 throughout.
REQ-032 rnd held at 500, single req pulse, defaults -> x=20, y=20; valid pulses once, 23 edges after the accept edge; busy high 24 cycles.
REQ-033 rnd=0 at accept, rnd=8191 at the WAIT exit, defaults -> x=0, y=31; qy=68, so latency = 1+14+69 = 84 edges.
REQ-034 req held high continuously, rnd held at 159 -> x=159, y=39 each cycle.
  - qx=0, qy=1, so latency = 1+14+2 = 17 edges, DONE cycle, then one IDLE cycle.
  - New accepts SHALL occur every 19 cycles; valid SHALL never be high two consecutive cycles.
REQ-035 Reset asserted in the 5th WAIT cycle -> busy and valid drop immediately, x returns to 0, no valid pulse; the next req completes normally.
REQ-036 Randomised rnd with a golden mod model, 1000 requests -> every x < 160, every y < 120, results match the model, latency matches REQ-019.
